// File: rtl/gate_pkg.sv
// gate_pkg: shared definitions for the gate_pipe family.
//   - gate_op_e : 3-bit gate function select (AND, OR, NAND, NOR, XOR, XNOR, NOT a, BUF a)
//   - OP_W      : width of the op field
//   - gate_bit  : single-bit gate function, applied bit-wise by gate_op_unit
package gate_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NAND = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOT  = 3'd6,
    OP_BUF  = 3'd7
  } gate_op_e;

  // One bit of f(op, a, b). NOT and BUF ignore the b input.
  function automatic logic gate_bit(input gate_op_e op, input logic x, input logic z);
    logic r;
    case (op)
      OP_AND:  r = x & z;
      OP_OR:   r = x | z;
      OP_NAND: r = ~(x & z);
      OP_NOR:  r = ~(x | z);
      OP_XOR:  r = x ^ z;
      OP_XNOR: r = ~(x ^ z);
      OP_NOT:  r = ~x;
      OP_BUF:  r = x;
      default: r = x;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gate_op_unit.sv
// gate_op_unit: purely combinational WIDTH-bit gate function y = f(op, a, b).
// Ports:
//   op  in  OP_W   gate function select (gate_pkg::gate_op_e encoding)
//   a   in  WIDTH  operand A
//   b   in  WIDTH  operand B (ignored for NOT / BUF)
//   y   out WIDTH  result
module gate_op_unit
  import gate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  gate_op_e op_e;

  // Apply the selected single-bit gate to every bit position.
  always_comb begin
    op_e = gate_op_e'(op);
    y    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      y[i] = gate_bit(op_e, a[i], b[i]);
    end
  end

endmodule

// File: rtl/gate_pipe.sv
// gate_pipe: 2-stage valid/ready pipelined gate unit.
// S1 registers f(op, a, b); S2 registers the result plus reduction flags,
// so y_zero / y_ones / y_par always describe the y currently presented.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid / in_ready input handshake (in_ready is combinational)
//   op, a, b            gate function and operands, sampled on accept
//   out_valid/out_ready output handshake
//   y                   registered result
//   y_zero, y_ones      y == 0, y == all ones
//   y_par               XOR-reduction of y
//   txn_cnt             wrapping count of output handshakes
module gate_pipe
  import gate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_zero,
  output logic             y_ones,
  output logic             y_par,
  output logic [CNT_W-1:0] txn_cnt
);

  logic [WIDTH-1:0] f_y;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_y_q,     s1_y_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] y_q,        y_d;
  logic             y_zero_q,   y_zero_d;
  logic             y_ones_q,   y_ones_d;
  logic             y_par_q,    y_par_d;
  logic [CNT_W-1:0] txn_cnt_q,  txn_cnt_d;

  logic s2_load;
  logic s1_load;
  logic out_hs;

  gate_op_unit #(.WIDTH(WIDTH)) u_op (
    .op (op),
    .a  (a),
    .b  (b),
    .y  (f_y)
  );

  // Handshake decisions and next-state for both stages and the counter.
  always_comb begin
    // S2 takes the S1 word when it is empty or its word leaves this cycle.
    s2_load  = s1_valid_q && (!out_valid_q || out_ready);
    s1_load  = in_valid && (!s1_valid_q || s2_load);
    in_ready = !s1_valid_q || !out_valid_q || out_ready;
    out_hs   = out_valid_q && out_ready;

    if (s1_load) begin
      s1_valid_d = 1'b1;
      s1_y_d     = f_y;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
      s1_y_d     = s1_y_q;
    end else begin
      s1_valid_d = s1_valid_q;
      s1_y_d     = s1_y_q;
    end

    // Flags are derived from the word being loaded so they never lag y.
    if (s2_load) begin
      out_valid_d = 1'b1;
      y_d         = s1_y_q;
      y_zero_d    = (s1_y_q == '0);
      y_ones_d    = &s1_y_q;
      y_par_d     = ^s1_y_q;
    end else if (out_hs) begin
      out_valid_d = 1'b0;
      y_d         = y_q;
      y_zero_d    = y_zero_q;
      y_ones_d    = y_ones_q;
      y_par_d     = y_par_q;
    end else begin
      out_valid_d = out_valid_q;
      y_d         = y_q;
      y_zero_d    = y_zero_q;
      y_ones_d    = y_ones_q;
      y_par_d     = y_par_q;
    end

    if (out_hs) begin
      txn_cnt_d = txn_cnt_q + CNT_W'(1);
    end else begin
      txn_cnt_d = txn_cnt_q;
    end
  end

  // Pipeline and counter state; reset discards any in-flight words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_y_q      <= '0;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      y_zero_q    <= 1'b1;
      y_ones_q    <= 1'b0;
      y_par_q     <= 1'b0;
      txn_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_y_q      <= s1_y_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      y_zero_q    <= y_zero_d;
      y_ones_q    <= y_ones_d;
      y_par_q     <= y_par_d;
      txn_cnt_q   <= txn_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign y_zero    = y_zero_q;
  assign y_ones    = y_ones_q;
  assign y_par     = y_par_q;
  assign txn_cnt   = txn_cnt_q;

endmodule
